// File: rtl/pw_pattern_matcher_mc.sv
// pw_pattern_matcher_mc: multi-channel masked byte-pattern matcher (fe_clk domain).
// Keeps a sliding window of recent valid bytes and compares it against
// pCHANNELS pattern/mask pairs, counts occurrences and fires on the Nth one.
// Optional feature: define PW_PM_SEQUENCE_EN to chain channels in order
// (channel c>0 only hits after channel c-1 has hit; only the last channel counts).

`ifndef PM_CAPTURE
`define PM_CAPTURE 2'd1
`endif
`ifndef PM_TRIGGER
`define PM_TRIGGER 2'd2
`endif

module pw_pattern_matcher_mc #(
  parameter int unsigned pPATTERN_BYTES = 8,
  parameter int unsigned pCHANNELS      = 2,
  parameter int unsigned pCOUNT_WIDTH   = 8
) (
  input  logic                                  fe_clk,
  input  logic                                  reset_i,
  input  logic                                  I_arm,
  input  logic [pCHANNELS*pPATTERN_BYTES*8-1:0] I_pattern,
  input  logic [pCHANNELS*pPATTERN_BYTES*8-1:0] I_mask,
  input  logic [pCHANNELS*8-1:0]                I_pattern_bytes,
  input  logic [1:0]                            I_action,
  input  logic [pCOUNT_WIDTH-1:0]               I_match_count_target,
  input  logic [7:0]                            I_fe_data,
  input  logic                                  I_fe_data_valid,
  input  logic                                  I_capturing,
  output logic [pCHANNELS-1:0]                  O_match,
  output logic [pCOUNT_WIDTH-1:0]               O_match_count,
  output logic                                  O_match_capture,
  output logic                                  O_match_trigger
);

  localparam int unsigned FILL_W = $clog2(pPATTERN_BYTES + 1);

  logic [7:0]              window [pPATTERN_BYTES];
  logic [7:0]              hist   [pPATTERN_BYTES+1];
  logic [FILL_W-1:0]       fill;
  logic [pCHANNELS-1:0]    match_q;
  logic [pCHANNELS-1:0]    hit;
  logic [pCHANNELS-1:0]    eff_hit;
  logic [pCOUNT_WIDTH-1:0] count_q;
  logic [pCOUNT_WIDTH-1:0] count_inc;
  logic [pCOUNT_WIDTH-1:0] target_eff;
  logic                    fired_q;
  logic                    trig_q;
  logic                    capturing_q;
  logic                    clear;
  logic                    advance;
  logic                    count_hit;
  logic                    fire_now;

  // Clear on disarm or when a fired capture finishes; advance on every other valid byte.
  always_comb begin
    clear      = ~I_arm | (fired_q & capturing_q & ~I_capturing);
    advance    = I_fe_data_valid & ~clear;
    count_inc  = (&count_q) ? count_q : count_q + 1'b1;
    target_eff = (I_match_count_target == '0) ? pCOUNT_WIDTH'(1) : I_match_count_target;
  end

  // Per-channel hit against the current byte plus window; hist[k] is the byte k positions back.
  // Pattern byte i pairs with hist[L-1-i]; the i/k double loop avoids a variable array index.
  always_comb begin
    int unsigned len_c;
    logic        ok;
    hit     = '0;
    hist[0] = I_fe_data;
    for (int unsigned k = 1; k <= pPATTERN_BYTES; k++) begin
      hist[k] = window[k-1];
    end
    for (int unsigned c = 0; c < pCHANNELS; c++) begin
      len_c = 32'(I_pattern_bytes[c*8 +: 8]);
      if (len_c > pPATTERN_BYTES) begin
        len_c = pPATTERN_BYTES;
      end
      ok = (len_c != 0) && (32'(fill) + 1 >= len_c);
      for (int unsigned i = 0; i < pPATTERN_BYTES; i++) begin
        for (int unsigned k = 0; k <= pPATTERN_BYTES; k++) begin
          if ((i < len_c) && (i + k + 1 == len_c) &&
              (((I_pattern[(c*pPATTERN_BYTES+i)*8 +: 8] ^ hist[k]) &
                I_mask[(c*pPATTERN_BYTES+i)*8 +: 8]) != 8'h00)) begin
            ok = 1'b0;
          end
        end
      end
      hit[c] = ok;
    end
  end

  // Channel gating: independent OR, or an ordered chain when sequencing is enabled.
  always_comb begin
`ifdef PW_PM_SEQUENCE_EN
    eff_hit    = '0;
    eff_hit[0] = hit[0];
    for (int unsigned c = 1; c < pCHANNELS; c++) begin
      eff_hit[c] = hit[c] & match_q[c-1];
    end
    count_hit = eff_hit[pCHANNELS-1];
`else
    eff_hit   = hit;
    count_hit = |hit;
`endif
    fire_now = advance & count_hit & ~fired_q & (count_inc == target_eff);
  end

  // Track I_capturing to detect the end of a capture.
  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      capturing_q <= 1'b0;
    end else begin
      capturing_q <= I_capturing;
    end
  end

  // Sliding window and saturating fill counter.
  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      window <= '{default: '0};
      fill   <= '0;
    end else if (clear) begin
      window <= '{default: '0};
      fill   <= '0;
    end else if (I_fe_data_valid) begin
      window[0] <= I_fe_data;
      for (int unsigned k = 1; k < pPATTERN_BYTES; k++) begin
        window[k] <= window[k-1];
      end
      if (fill != FILL_W'(pPATTERN_BYTES)) begin
        fill <= fill + 1'b1;
      end
    end
  end

  // Sticky hit flags, occurrence counter, fired flag and one-shot trigger.
  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      match_q <= '0;
      count_q <= '0;
      fired_q <= 1'b0;
      trig_q  <= 1'b0;
    end else if (clear) begin
      match_q <= '0;
      count_q <= '0;
      fired_q <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      trig_q <= 1'b0;
      if (advance) begin
        match_q <= match_q | eff_hit;
        if (count_hit && !fired_q) begin
          count_q <= count_inc;
        end
        if (fire_now) begin
          fired_q <= 1'b1;
          trig_q  <= (I_action == `PM_TRIGGER);
        end
      end
    end
  end

  // Output mapping.
  always_comb begin
    O_match         = match_q;
    O_match_count   = count_q;
    O_match_trigger = trig_q;
    O_match_capture = fired_q & (I_action == `PM_CAPTURE);
  end

endmodule

// File: tb/tb_pw_pattern_matcher_mc.sv
// Testbench for pw_pattern_matcher_mc: a history-based reference model pushes
// expected outputs into a scoreboard queue each cycle; they are popped and
// compared one time unit after the clock edge.

`ifndef PM_CAPTURE
`define PM_CAPTURE 2'd1
`endif
`ifndef PM_TRIGGER
`define PM_TRIGGER 2'd2
`endif

module tb_pw_pattern_matcher_mc;

  localparam int P = 8;
  localparam int C = 2;
  localparam int W = 8;

  logic             fe_clk = 1'b0;
  logic             reset_i;
  logic             I_arm;
  logic [C*P*8-1:0] I_pattern;
  logic [C*P*8-1:0] I_mask;
  logic [C*8-1:0]   I_pattern_bytes;
  logic [1:0]       I_action;
  logic [W-1:0]     I_match_count_target;
  logic [7:0]       I_fe_data;
  logic             I_fe_data_valid;
  logic             I_capturing;
  logic [C-1:0]     O_match;
  logic [W-1:0]     O_match_count;
  logic             O_match_capture;
  logic             O_match_trigger;

  logic [7:0] pat [C][P];
  logic [7:0] msk [C][P];
  logic [7:0] len [C];

  typedef struct packed {
    logic [C-1:0] match;
    logic [W-1:0] count;
    logic         cap;
    logic         trig;
  } exp_t;

  exp_t        sb [$];
  logic [7:0]  mh [$];
  logic [C-1:0] m_match;
  logic [W-1:0] m_count;
  logic         m_fired, m_trig, m_capq;
  int           n_checks = 0;
  int           n_fail   = 0;

  always #5 fe_clk = ~fe_clk;

  always_comb begin
    for (int c = 0; c < C; c++) begin
      I_pattern_bytes[c*8 +: 8] = len[c];
      for (int i = 0; i < P; i++) begin
        I_pattern[(c*P+i)*8 +: 8] = pat[c][i];
        I_mask[(c*P+i)*8 +: 8]    = msk[c][i];
      end
    end
  end

  pw_pattern_matcher_mc #(
    .pPATTERN_BYTES(P),
    .pCHANNELS     (C),
    .pCOUNT_WIDTH  (W)
  ) dut (
    .fe_clk              (fe_clk),
    .reset_i             (reset_i),
    .I_arm               (I_arm),
    .I_pattern           (I_pattern),
    .I_mask              (I_mask),
    .I_pattern_bytes     (I_pattern_bytes),
    .I_action            (I_action),
    .I_match_count_target(I_match_count_target),
    .I_fe_data           (I_fe_data),
    .I_fe_data_valid     (I_fe_data_valid),
    .I_capturing         (I_capturing),
    .O_match             (O_match),
    .O_match_count       (O_match_count),
    .O_match_capture     (O_match_capture),
    .O_match_trigger     (O_match_trigger)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mh.delete();
    m_match = '0;
    m_count = '0;
    m_fired = 1'b0;
    m_trig  = 1'b0;
    m_capq  = 1'b0;
  endtask

  // Reference: match the tail of the received-byte history against each pattern.
  task automatic model_step();
    logic         clr, ok, any;
    logic [C-1:0] h, e;
    logic [W-1:0] nc, tgt;
    int           l;
    exp_t         x;
    clr    = !I_arm || (m_fired && m_capq && !I_capturing);
    m_trig = 1'b0;
    if (clr) begin
      mh.delete();
      m_match = '0;
      m_count = '0;
      m_fired = 1'b0;
    end else if (I_fe_data_valid) begin
      mh.push_back(I_fe_data);
      if (mh.size() > P) void'(mh.pop_front());
      for (int c = 0; c < C; c++) begin
        l  = (int'(len[c]) > P) ? P : int'(len[c]);
        ok = (l > 0) && (mh.size() >= l);
        if (ok) begin
          for (int i = 0; i < l; i++) begin
            if (((pat[c][i] ^ mh[mh.size()-l+i]) & msk[c][i]) != 8'h00) ok = 1'b0;
          end
        end
        h[c] = ok;
      end
`ifdef PW_PM_SEQUENCE_EN
      e[0] = h[0];
      e[1] = h[1] & m_match[0];
      any  = e[1];
`else
      e   = h;
      any = |h;
`endif
      m_match = m_match | e;
      if (any && !m_fired) begin
        nc      = (m_count == '1) ? m_count : m_count + 1'b1;
        m_count = nc;
        tgt     = (I_match_count_target == '0) ? W'(1) : I_match_count_target;
        if (nc == tgt) begin
          m_fired = 1'b1;
          m_trig  = (I_action == `PM_TRIGGER);
        end
      end
    end
    m_capq  = I_capturing;
    x.match = m_match;
    x.count = m_count;
    x.cap   = m_fired && (I_action == `PM_CAPTURE);
    x.trig  = m_trig;
    sb.push_back(x);
  endtask

  task automatic step();
    exp_t x;
    model_step();
    @(posedge fe_clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      check_eq("match",   32'(O_match),         32'(x.match));
      check_eq("count",   32'(O_match_count),   32'(x.count));
      check_eq("capture", 32'(O_match_capture), 32'(x.cap));
      check_eq("trigger", 32'(O_match_trigger), 32'(x.trig));
    end
  endtask

  task automatic feed(input logic [7:0] b);
    I_fe_data       = b;
    I_fe_data_valid = 1'b1;
    step();
    I_fe_data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    I_fe_data_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rearm();
    I_arm = 1'b0;
    step();
    I_arm = 1'b1;
  endtask

  task automatic cfg(input int c, input logic [7:0] l, input logic [31:0] p, input logic [31:0] m);
    len[c] = l;
    for (int i = 0; i < P; i++) begin
      pat[c][i] = (i < 4) ? p[31-8*i -: 8] : 8'h00;
      msk[c][i] = (i < 4) ? m[31-8*i -: 8] : 8'h00;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_match"}, 32'(O_match), 32'd0);
    check_eq({tag, "_count"}, 32'(O_match_count), 32'd0);
    check_eq({tag, "_cap"},   32'(O_match_capture), 32'd0);
    check_eq({tag, "_trig"},  32'(O_match_trigger), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1; I_arm = 1'b0; I_action = 2'd0; I_match_count_target = '0;
    I_fe_data = '0; I_fe_data_valid = 1'b0; I_capturing = 1'b0;
    cfg(0, 8'd0, 32'h0, 32'h0);
    cfg(1, 8'd0, 32'h0, 32'h0);
    model_reset();
    repeat (2) @(posedge fe_clk);
    #1;
    check_all_zero("reset");
    reset_i = 1'b0;
    I_arm   = 1'b1;

    // Basic trigger on DE AD BE.
    cfg(0, 8'd3, 32'hDEADBE00, 32'hFFFFFF00);
    I_match_count_target = 8'd1; I_action = `PM_TRIGGER;
    feed(8'h00); feed(8'hDE); feed(8'hAD); feed(8'hBE);
    idle(3);
    rearm();

    // Restarting pattern DE DE AD inside DE DE DE AD.
    cfg(0, 8'd3, 32'hDEDEAD00, 32'hFFFFFF00);
    I_action = 2'd0;
    feed(8'hDE); feed(8'hDE); feed(8'hDE); feed(8'hAD);
    idle(1);
    rearm();

    // Masked match on channel 1, then a masked miss.
    cfg(0, 8'd0, 32'h0, 32'h0);
    cfg(1, 8'd2, 32'hA0050000, 32'hF00F0000);
    I_match_count_target = 8'd5;
    feed(8'hA7); feed(8'h35); feed(8'hB7); feed(8'h35);
    rearm();

    // Nth occurrence with idle gaps; zero target behaves as one afterwards.
    cfg(1, 8'd0, 32'h0, 32'h0);
    cfg(0, 8'd3, 32'hDEADBE00, 32'hFFFFFF00);
    I_match_count_target = 8'd3; I_action = `PM_TRIGGER;
    for (int r = 0; r < 4; r++) begin
      feed(8'hDE); idle(1); feed(8'hAD); idle(2); feed(8'hBE); idle(1);
    end
    rearm();
    I_match_count_target = 8'd0;
    feed(8'hDE); feed(8'hAD); feed(8'hBE); idle(1);
    rearm();

    // Capture level then capture-done clear with a simultaneous hit byte.
    I_match_count_target = 8'd1; I_action = `PM_CAPTURE; I_capturing = 1'b1;
    feed(8'hDE); feed(8'hAD); feed(8'hBE); idle(2);
    feed(8'hDE); feed(8'hAD);
    I_capturing = 1'b0;
    feed(8'hBE);
    idle(2);
    rearm();

    // Asynchronous reset mid-pattern.
    feed(8'hDE); feed(8'hAD);
    #2 reset_i = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(posedge fe_clk);
    #1 reset_i = 1'b0;

    // Channel ordering: ch1 pattern first, then ch0 followed by ch1.
    cfg(0, 8'd2, 32'h11220000, 32'hFFFF0000);
    cfg(1, 8'd2, 32'h33440000, 32'hFFFF0000);
    I_action = `PM_TRIGGER; I_match_count_target = 8'd1;
    feed(8'h33); feed(8'h44); idle(1);
    feed(8'h11); feed(8'h22); feed(8'h33); feed(8'h44); idle(1);
    rearm();

    // Random stream over a small alphabet with gaps, action and capture changes.
    cfg(0, 8'd2, 32'hDEAD0000, 32'hFFFF0000);
    cfg(1, 8'd3, 32'hADBEAD00, 32'hFFFFFF00);
    I_match_count_target = 8'd4;
    for (int n = 0; n < 150; n++) begin
      logic [7:0] alpha [4];
      alpha = '{8'hDE, 8'hAD, 8'hBE, 8'h00};
      I_fe_data       = alpha[$urandom_range(0, 3)];
      I_fe_data_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) I_action = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) I_capturing = ~I_capturing;
      I_arm = ($urandom_range(0, 39) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
